// File: rtl/regbank.sv
// -----------------------------------------------------------------------------
// regbank: general-purpose register file (NREGS x WIDTH).
//
// Receives writes from the control unit (regbank_we / regbank_sel /
// regbank_valin). It serves two independent read ports, and each port has
// one cycle of registered latency. After reset, a sweep clears every entry
// one per cycle. When the sweep is done, regbank_ready is raised and normal
// operation starts.
//
// Ports:
//   clk            in   1      clock, all logic on posedge
//   rst_n          in   1      asynchronous active-low reset
//   regbank_we     in   1      write enable
//   regbank_sel    in   SEL_W  write index (>= NREGS is silently dropped)
//   regbank_valin  in   WIDTH  write data
//   rd_sel_a/b     in   SEL_W  read indices (>= NREGS reads 0)
//   rd_val_a/b     out  WIDTH  registered read data, write-first bypass
//   regbank_ready  out  1      sweep complete
//   regbank_wack   out  1      write accepted on the previous cycle
// -----------------------------------------------------------------------------
module regbank #(
  parameter int NREGS = 64,
  parameter int WIDTH = 64,
  parameter int SEL_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             regbank_we,
  input  logic [SEL_W-1:0] regbank_sel,
  input  logic [WIDTH-1:0] regbank_valin,
  input  logic [SEL_W-1:0] rd_sel_a,
  input  logic [SEL_W-1:0] rd_sel_b,
  output logic [WIDTH-1:0] rd_val_a,
  output logic [WIDTH-1:0] rd_val_b,
  output logic             regbank_ready,
  output logic             regbank_wack
);

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_t;

  // The sweep index has one extra bit, so NREGS == 2**SEL_W is representable.
  localparam logic [SEL_W:0] NREGS_C    = (SEL_W+1)'(NREGS);
  localparam logic [SEL_W:0] LAST_IDX_C = (SEL_W+1)'(NREGS - 1);
  localparam logic [SEL_W:0] ONE_C      = (SEL_W+1)'(1);

  state_t           state_r;
  state_t           state_s;
  logic [SEL_W:0]   clr_idx_r;
  logic [SEL_W:0]   clr_idx_s;
  logic             wr_en_s;
  logic [WIDTH-1:0] rd_a_s;
  logic [WIDTH-1:0] rd_b_s;
  logic [WIDTH-1:0] rd_val_a_r;
  logic [WIDTH-1:0] rd_val_b_r;
  logic             ready_r;
  logic             wack_r;
  logic [WIDTH-1:0] mem_r [NREGS];

  function automatic logic in_range(input logic [SEL_W-1:0] sel);
    return ({1'b0, sel} < NREGS_C);
  endfunction

  // FSM state and sweep index register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= CLEAR;
      clr_idx_r <= {(SEL_W+1){1'b0}};
    end else begin
      state_r   <= state_s;
      clr_idx_r <= clr_idx_s;
    end
  end

  // Next-state logic: sweep through all entries, then stay in READY until reset.
  always_comb begin
    state_s   = state_r;
    clr_idx_s = clr_idx_r;
    case (state_r)
      CLEAR: begin
        clr_idx_s = clr_idx_r + ONE_C;
        if (clr_idx_r == LAST_IDX_C) begin
          state_s = READY;
        end else begin
          state_s = CLEAR;
        end
      end
      READY: begin
        state_s   = READY;
        clr_idx_s = clr_idx_r;
      end
      default: begin
        state_s   = CLEAR;
        clr_idx_s = {(SEL_W+1){1'b0}};
      end
    endcase
  end

  // A write takes effect only after the sweep and only for an existing register.
  always_comb begin
    wr_en_s = 1'b0;
    if (state_r == READY) begin
      wr_en_s = regbank_we && in_range(regbank_sel);
    end else begin
      wr_en_s = 1'b0;
    end
  end

  // Storage: the sweep clears it, because the array has no reset.
  always_ff @(posedge clk) begin
    if (state_r == CLEAR) begin
      mem_r[clr_idx_r[SEL_W-1:0]] <= {WIDTH{1'b0}};
    end else if (wr_en_s) begin
      mem_r[regbank_sel] <= regbank_valin;
    end
  end

  // Read port A: the same-cycle write to the same index wins over the stored value.
  always_comb begin
    rd_a_s = {WIDTH{1'b0}};
    if (state_r != READY || !in_range(rd_sel_a)) begin
      rd_a_s = {WIDTH{1'b0}};
    end else if (wr_en_s && (regbank_sel == rd_sel_a)) begin
      rd_a_s = regbank_valin;
    end else begin
      rd_a_s = mem_r[rd_sel_a];
    end
  end

  // Read port B: same rules as port A, evaluated independently.
  always_comb begin
    rd_b_s = {WIDTH{1'b0}};
    if (state_r != READY || !in_range(rd_sel_b)) begin
      rd_b_s = {WIDTH{1'b0}};
    end else if (wr_en_s && (regbank_sel == rd_sel_b)) begin
      rd_b_s = regbank_valin;
    end else begin
      rd_b_s = mem_r[rd_sel_b];
    end
  end

  // Registered outputs: ready rises on the same edge as the last sweep write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_r    <= 1'b0;
      wack_r     <= 1'b0;
      rd_val_a_r <= {WIDTH{1'b0}};
      rd_val_b_r <= {WIDTH{1'b0}};
    end else begin
      ready_r    <= (state_s == READY);
      wack_r     <= wr_en_s;
      rd_val_a_r <= rd_a_s;
      rd_val_b_r <= rd_b_s;
    end
  end

  assign rd_val_a      = rd_val_a_r;
  assign rd_val_b      = rd_val_b_r;
  assign regbank_ready = ready_r;
  assign regbank_wack  = wack_r;

endmodule

// File: tb/tb_regbank.sv
// -----------------------------------------------------------------------------
// tb_regbank: scoreboard bench for regbank. Stimulus pushes expected
// responses tagged with the cycle in which they must be visible. A monitor
// compares them on the falling edge. A second instance with NREGS=48
// covers out-of-range writes and reads.
// -----------------------------------------------------------------------------
module tb_regbank;

  logic        clk;
  logic        rst_n, we, ready, wack;
  logic [5:0]  sel, rsa, rsb;
  logic [63:0] valin, rva, rvb;
  logic        rst2_n, we2, ready2, wack2;
  logic [5:0]  sel2, rsa2, rsb2;
  logic [63:0] valin2, rva2, rvb2;

  int cyc = 0;
  int n_cmp = 0;
  int n_mis = 0;

  typedef struct {
    int          cyc;
    int          kind;
    logic [63:0] exp;
  } sb_t;
  sb_t sb_q[$];

  regbank #(.NREGS(64), .WIDTH(64), .SEL_W(6)) dut (
    .clk(clk), .rst_n(rst_n), .regbank_we(we), .regbank_sel(sel),
    .regbank_valin(valin), .rd_sel_a(rsa), .rd_sel_b(rsb),
    .rd_val_a(rva), .rd_val_b(rvb), .regbank_ready(ready), .regbank_wack(wack)
  );

  regbank #(.NREGS(48), .WIDTH(64), .SEL_W(6)) dut48 (
    .clk(clk), .rst_n(rst2_n), .regbank_we(we2), .regbank_sel(sel2),
    .regbank_valin(valin2), .rd_sel_a(rsa2), .rd_sel_b(rsb2),
    .rd_val_a(rva2), .rd_val_b(rvb2), .regbank_ready(ready2), .regbank_wack(wack2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic string kname(input int k);
    case (k)
      0: return "rd_val_a";
      1: return "rd_val_b";
      2: return "wack";
      3: return "ready";
      4: return "rd_val_a48";
      5: return "rd_val_b48";
      6: return "wack48";
      7: return "ready48";
      default: return "unknown";
    endcase
  endfunction

  function automatic logic [63:0] sample(input int k);
    case (k)
      0: return rva;
      1: return rvb;
      2: return {63'd0, wack};
      3: return {63'd0, ready};
      4: return rva2;
      5: return rvb2;
      6: return {63'd0, wack2};
      7: return {63'd0, ready2};
      default: return 64'hDEAD_DEAD_DEAD_DEAD;
    endcase
  endfunction

  task automatic check(input int k, input logic [63:0] exp);
    logic [63:0] act;
    act = sample(k);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s @cyc %0d: got 0x%016h expected 0x%016h", kname(k), cyc, act, exp);
    end
  endtask

  // Expected value that must be visible after the next rising edge.
  task automatic push(input int k, input logic [63:0] v);
    sb_t e;
    e.cyc  = cyc + 1;
    e.kind = k;
    e.exp  = v;
    sb_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: compare every expectation that is due by this cycle.
  always @(negedge clk) begin
    while (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
      sb_t e;
      e = sb_q.pop_front();
      check(e.kind, e.exp);
    end
  end

  initial begin
    rst_n = 1'b0; we = 1'b0; sel = 6'd0; valin = 64'd0; rsa = 6'd0; rsb = 6'd0;
    rst2_n = 1'b0; we2 = 1'b0; sel2 = 6'd0; valin2 = 64'd0; rsa2 = 6'd0; rsb2 = 6'd0;
    repeat (3) tick();

    // Reset state.
    for (int k = 0; k < 4; k++) check(k, 64'd0);

    // 1: sweep with we held high; ready exactly 64 cycles after release.
    rst_n = 1'b1; we = 1'b1; sel = 6'd5; valin = 64'hAA;
    for (int k = 1; k <= 64; k++) begin
      push(3, (k == 64) ? 64'd1 : 64'd0);
      push(2, 64'd0);
      push(0, 64'd0);
      tick();
    end
    we = 1'b0;
    for (int i = 0; i < 64; i++) begin
      rsa = 6'(i); rsb = 6'(63 - i);
      push(0, 64'd0); push(1, 64'd0);
      tick();
    end

    // 2: single write, one-cycle wack, then read back.
    we = 1'b1; sel = 6'd3; valin = 64'hDEADBEEF_00000001;
    push(2, 64'd1);
    tick();
    we = 1'b0; rsa = 6'd3;
    push(2, 64'd0); push(0, 64'hDEADBEEF_00000001);
    tick();

    // 3: write-first bypass on both ports at once.
    we = 1'b1; sel = 6'd7; valin = 64'h1234; rsa = 6'd7; rsb = 6'd7;
    push(0, 64'h1234); push(1, 64'h1234); push(2, 64'd1);
    tick();
    we = 1'b0;
    push(2, 64'd0);
    tick();

    // 4: we held high over all indices, then read all back.
    for (int s = 0; s < 64; s++) begin
      we = 1'b1; sel = 6'(s); valin = 64'(s * 3);
      push(2, 64'd1);
      tick();
    end
    we = 1'b0;
    for (int i = 0; i < 64; i++) begin
      rsa = 6'(i); rsb = 6'(i);
      push(0, 64'(i * 3)); push(1, 64'(i * 3));
      tick();
    end

    // 5a: asynchronous reset in operation; outputs clear before the next edge.
    we = 1'b1; sel = 6'd3; valin = 64'h77; rsa = 6'd3; rsb = 6'd3;
    push(0, 64'h77); push(2, 64'd1);
    tick();
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    for (int k = 0; k < 4; k++) check(k, 64'd0);
    we = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    // 5b: reset again at sweep index 20.
    for (int k = 1; k <= 20; k++) begin
      push(3, 64'd0);
      tick();
    end
    rst_n = 1'b0;
    #1;
    check(3, 64'd0);
    repeat (2) tick();
    rst_n = 1'b1;
    for (int k = 1; k <= 64; k++) begin
      push(3, (k == 64) ? 64'd1 : 64'd0);
      tick();
    end
    for (int i = 0; i < 64; i++) begin
      rsa = 6'(i); rsb = 6'(63 - i);
      push(0, 64'd0); push(1, 64'd0);
      tick();
    end

    // 6: NREGS=48 instance, out-of-range write and read.
    rst2_n = 1'b1;
    for (int k = 1; k <= 48; k++) begin
      push(7, (k == 48) ? 64'd1 : 64'd0);
      tick();
    end
    we2 = 1'b1; sel2 = 6'd10; valin2 = 64'h55;
    push(6, 64'd1);
    tick();
    sel2 = 6'd50; valin2 = 64'hFFFF;
    push(6, 64'd0);
    tick();
    we2 = 1'b0; rsa2 = 6'd50; rsb2 = 6'd10;
    push(6, 64'd0); push(4, 64'd0); push(5, 64'h55);
    tick();
    for (int i = 0; i < 48; i++) begin
      rsa2 = 6'(i); rsb2 = 6'(47 - i);
      push(4, (i == 10) ? 64'h55 : 64'd0);
      push(5, ((47 - i) == 10) ? 64'h55 : 64'd0);
      tick();
    end

    repeat (3) tick();
    if (sb_q.size() != 0) begin
      n_cmp++;
      n_mis++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
